// File: rtl/sgpr_rd_arbiter.sv
// sgpr_rd_arbiter: shares one SGPR read channel among NUM_REQ issue units.
// Requests are granted round-robin and a grant stays locked until it fires.
// Every accepted requester ID goes into an in-order tracking FIFO, and each
// SGPR response is routed back to the requester at the FIFO head.
module sgpr_rd_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int REQ_W   = 32,
    parameter int RESP_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*REQ_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [RESP_W-1:0]            resp_data,
    output logic                         sgpr_rd_req_valid,
    input  logic                         sgpr_rd_req_ready,
    output logic [REQ_W-1:0]             sgpr_rd_req_data,
    input  logic                         sgpr_rd_resp_valid,
    output logic                         sgpr_rd_resp_ready,
    input  logic [RESP_W-1:0]            sgpr_rd_resp_data,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         err_orphan_resp
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    // Per-requester view of the packed request bus
    logic [REQ_W-1:0] req_slot [NUM_REQ];

    // Arbitration state
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic             locked_reg, locked_next;
    logic [ID_W-1:0]  lock_id_reg, lock_id_next;

    // Tracking FIFO; pointers carry one extra MSB so full and empty differ
    logic [ID_W-1:0]  fifo_mem [MAX_OUT];
    logic [CNT_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic             fifo_full, fifo_empty;
    logic [ID_W-1:0]  head_id;

    // Arbitration results
    logic [ID_W-1:0]  cand_idx;
    logic [ID_W-1:0]  rr_win;
    logic             rr_found;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic             push, pop;
    logic             err_orphan_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
            assign req_slot[gi] = req_data[gi*REQ_W +: REQ_W];
        end
    endgenerate

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign head_id    = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

    // Round-robin search starting at rr_ptr; first valid requester wins
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(rr_ptr_reg) + k >= NUM_REQ)
                cand_idx = ID_W'(int'(rr_ptr_reg) + k - NUM_REQ);
            else
                cand_idx = ID_W'(int'(rr_ptr_reg) + k);
            if (!rr_found && req_valid[cand_idx]) begin
                rr_found = 1'b1;
                rr_win   = cand_idx;
            end
        end
    end

    // Locked grant overrides the search; a dropped valid leaves no winner
    always_comb begin
        if (locked_reg) begin
            win_id    = lock_id_reg;
            win_found = req_valid[lock_id_reg];
        end else begin
            win_id    = rr_win;
            win_found = rr_found;
        end
    end

    // Downstream request / upstream response handshakes, gated by reset
    always_comb begin
        sgpr_rd_req_valid  = rst_n && win_found && !fifo_full;
        sgpr_rd_req_data   = req_slot[win_id];
        push               = sgpr_rd_req_valid && sgpr_rd_req_ready;
        sgpr_rd_resp_ready = rst_n && !fifo_empty && resp_ready[head_id];
        pop                = sgpr_rd_resp_ready && sgpr_rd_resp_valid;
        resp_data          = sgpr_rd_resp_data;
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_route
            assign req_ready[gi]  = push && (win_id == ID_W'(gi));
            assign resp_valid[gi] = rst_n && !fifo_empty && sgpr_rd_resp_valid &&
                                    (head_id == ID_W'(gi));
        end
    endgenerate

    // Next grant state: lock while presented but stalled, advance pointer on fire
    always_comb begin
        rr_ptr_next  = rr_ptr_reg;
        locked_next  = sgpr_rd_req_valid && !sgpr_rd_req_ready;
        lock_id_next = lock_id_reg;
        if (sgpr_rd_req_valid && !sgpr_rd_req_ready)
            lock_id_next = win_id;
        if (push)
            rr_ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end

    // Grant state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg  <= '0;
            locked_reg  <= 1'b0;
            lock_id_reg <= '0;
        end else begin
            rr_ptr_reg  <= rr_ptr_next;
            locked_reg  <= locked_next;
            lock_id_reg <= lock_id_next;
        end
    end

    // FIFO pointers; push is already blocked when full, so pop cannot free a slot for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
        end
    end

    // FIFO storage of granted requester IDs
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= win_id;
    end

    // Sticky flag for a response that has no matching request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_orphan_reg <= 1'b0;
        else if (sgpr_rd_resp_valid && fifo_empty)
            err_orphan_reg <= 1'b1;
    end

    assign err_orphan_resp = err_orphan_reg;
    assign outstanding     = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: tb/tb_sgpr_rd_arbiter.sv
// Testbench for sgpr_rd_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model of the arbiter.
module tb_sgpr_rd_arbiter;

    localparam int N       = 3;
    localparam int REQ_W   = 32;
    localparam int RESP_W  = 64;
    localparam int MAX_OUT = 4;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*REQ_W-1:0] req_data;
    logic [N-1:0]       resp_valid;
    logic [N-1:0]       resp_ready;
    logic [RESP_W-1:0]  resp_data;
    logic               sgpr_rd_req_valid;
    logic               sgpr_rd_req_ready;
    logic [REQ_W-1:0]   sgpr_rd_req_data;
    logic               sgpr_rd_resp_valid;
    logic               sgpr_rd_resp_ready;
    logic [RESP_W-1:0]  sgpr_rd_resp_data;
    logic [2:0]         outstanding;
    logic               err_orphan_resp;

    sgpr_rd_arbiter #(.NUM_REQ(N), .REQ_W(REQ_W), .RESP_W(RESP_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .sgpr_rd_req_valid(sgpr_rd_req_valid), .sgpr_rd_req_ready(sgpr_rd_req_ready),
        .sgpr_rd_req_data(sgpr_rd_req_data),
        .sgpr_rd_resp_valid(sgpr_rd_resp_valid), .sgpr_rd_resp_ready(sgpr_rd_resp_ready),
        .sgpr_rd_resp_data(sgpr_rd_resp_data),
        .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state
    int q_ids[$];
    int grant_log[$];
    int m_rr   = 0;
    int m_lock = -1;
    bit m_err  = 0;
    int m_win;
    bit m_dvalid, m_push, m_pop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        if (m_lock >= 0)
            return req_valid[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N])
                return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        q_ids.delete();
        m_rr   = 0;
        m_lock = -1;
        m_err  = 0;
    endtask

    // Let inputs settle, then compare every output against the model
    task automatic settle();
        logic [N-1:0] exp_rr, exp_rv;
        int head;
        bit exp_rrdy;
        #2;
        m_win    = model_winner();
        m_dvalid = (m_win >= 0) && (q_ids.size() < MAX_OUT);
        m_push   = m_dvalid && sgpr_rd_req_ready;
        exp_rr   = m_push ? N'(1 << m_win) : '0;
        head     = (q_ids.size() > 0) ? q_ids[0] : -1;
        exp_rv   = (head >= 0 && sgpr_rd_resp_valid) ? N'(1 << head) : '0;
        exp_rrdy = (head >= 0) && resp_ready[head];
        m_pop    = exp_rrdy && sgpr_rd_resp_valid;
        chk("req_ready", req_ready, exp_rr);
        chk("dn_req_valid", sgpr_rd_req_valid, m_dvalid);
        if (m_dvalid)
            chk("dn_req_data", sgpr_rd_req_data, req_data[m_win*REQ_W +: REQ_W]);
        chk("resp_valid", resp_valid, exp_rv);
        chk("dn_resp_ready", sgpr_rd_resp_ready, exp_rrdy);
        chk("resp_data", resp_data, sgpr_rd_resp_data);
        chk("outstanding", outstanding, q_ids.size());
        chk("err_orphan", err_orphan_resp, m_err);
        $display("t=%0t rv=%b rr=%b dv=%b resp_v=%b resp_r=%b out=%0d err=%b",
                 $time, req_valid, req_ready, sgpr_rd_req_valid, resp_valid,
                 sgpr_rd_resp_ready, outstanding, err_orphan_resp);
    endtask

    // Clock edge: advance the model with the handshakes predicted in settle()
    task automatic tick();
        @(posedge clk);
        if (sgpr_rd_resp_valid && q_ids.size() == 0)
            m_err = 1;
        if (m_pop)
            void'(q_ids.pop_front());
        if (m_push) begin
            q_ids.push_back(m_win);
            grant_log.push_back(m_win);
            m_rr   = (m_win + 1) % N;
            m_lock = -1;
        end else if (m_dvalid) begin
            m_lock = m_win;
        end else begin
            m_lock = -1;
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_resp_valid"}, resp_valid, '0);
        chk({tag, "_dn_req_valid"}, sgpr_rd_req_valid, 1'b0);
        chk({tag, "_dn_resp_ready"}, sgpr_rd_resp_ready, 1'b0);
        chk({tag, "_outstanding"}, outstanding, 0);
        chk({tag, "_err"}, err_orphan_resp, 1'b0);
    endtask

    task automatic drain();
        req_valid          = '0;
        resp_ready         = '1;
        sgpr_rd_resp_valid = 1'b1;
        for (int i = 0; i < MAX_OUT + 2 && q_ids.size() > 0; i++) begin
            sgpr_rd_resp_data = {$urandom, $urandom};
            settle();
            tick();
        end
        sgpr_rd_resp_valid = 1'b0;
        chk("drain_outstanding", outstanding, 0);
    endtask

    initial begin
        int exp_rr_order[6] = '{0, 1, 2, 0, 1, 2};

        // Reset asserted with busy inputs: handshake outputs must stay low
        rst_n              = 1'b0;
        req_valid          = '1;
        req_data           = {$urandom, $urandom, $urandom};
        resp_ready         = '1;
        sgpr_rd_req_ready  = 1'b1;
        sgpr_rd_resp_valid = 1'b1;
        sgpr_rd_resp_data  = {$urandom, $urandom};
        #3;
        check_reset_outputs("reset");
        sgpr_rd_resp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Round-robin with all requesters valid and the SGPR side always ready
        grant_log.delete();
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            req_data           = {$urandom, $urandom, $urandom};
            sgpr_rd_resp_valid = (q_ids.size() > 0);
            sgpr_rd_resp_data  = {$urandom, $urandom};
            settle();
            tick();
        end
        for (int i = 0; i < 6; i++)
            chk($sformatf("rr_order_%0d", i), (i < grant_log.size()) ? grant_log[i] : -1,
                exp_rr_order[i]);
        drain();

        // Lock: requester 2 stalled three cycles while requester 0 also asks
        req_valid         = 3'b100;
        req_data          = {$urandom, $urandom, $urandom};
        sgpr_rd_req_ready = 1'b0;
        settle();
        chk("lock_first_data", sgpr_rd_req_data, req_data[2*REQ_W +: REQ_W]);
        tick();
        req_valid = 3'b101;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("lock_hold_data", sgpr_rd_req_data, req_data[2*REQ_W +: REQ_W]);
            chk("lock_hold_ready", req_ready, 3'b000);
            tick();
        end
        sgpr_rd_req_ready = 1'b1;
        settle();
        chk("lock_fire", req_ready, 3'b100);
        tick();
        settle();
        chk("lock_next", req_ready, 3'b001);
        tick();
        drain();

        // Single requester, then its response
        req_valid = 3'b010;
        settle();
        chk("single_req_ready", req_ready, 3'b010);
        tick();
        chk("single_outstanding", outstanding, 1);
        req_valid          = '0;
        resp_ready         = 3'b010;
        sgpr_rd_resp_valid = 1'b1;
        sgpr_rd_resp_data  = {$urandom, $urandom};
        settle();
        chk("single_resp_valid", resp_valid, 3'b010);
        tick();
        chk("single_drained", outstanding, 0);
        sgpr_rd_resp_valid = 1'b0;

        // Full FIFO: four accepted, fifth held off, pop does not make room same cycle
        req_valid  = '1;
        resp_ready = '1;
        for (int c = 0; c < MAX_OUT; c++) begin
            settle();
            tick();
        end
        chk("full_count", outstanding, MAX_OUT);
        settle();
        chk("full_dn_valid", sgpr_rd_req_valid, 1'b0);
        tick();
        sgpr_rd_resp_valid = 1'b1;
        settle();
        chk("full_pop_req_ready", req_ready, 3'b000);
        chk("full_pop_resp_ready", sgpr_rd_resp_ready, 1'b1);
        tick();
        chk("full_after_pop", outstanding, MAX_OUT - 1);
        sgpr_rd_resp_valid = 1'b0;
        settle();
        chk("full_refill_valid", sgpr_rd_req_valid, 1'b1);
        chk("full_refill_ready", req_ready != '0, 1'b1);
        tick();
        chk("full_refilled", outstanding, MAX_OUT);
        drain();

        // Ordering: requests 1, 0, 2 are answered in that order; resp_ready[1] backpressure
        req_valid = 3'b010; settle(); tick();
        req_valid = 3'b001; settle(); tick();
        req_valid = 3'b100; settle(); tick();
        req_valid          = '0;
        resp_ready         = 3'b101;
        sgpr_rd_resp_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("order_bp_resp_valid", resp_valid, 3'b010);
            chk("order_bp_resp_ready", sgpr_rd_resp_ready, 1'b0);
            tick();
        end
        resp_ready = '1;
        settle(); chk("order_first", resp_valid, 3'b010); tick();
        settle(); chk("order_second", resp_valid, 3'b001); tick();
        settle(); chk("order_third", resp_valid, 3'b100); tick();
        sgpr_rd_resp_valid = 1'b0;
        chk("order_drained", outstanding, 0);

        // Orphan response: ready stays low and the flag sticks
        sgpr_rd_resp_valid = 1'b1;
        settle();
        chk("orphan_ready", sgpr_rd_resp_ready, 1'b0);
        tick();
        sgpr_rd_resp_valid = 1'b0;
        chk("orphan_flag", err_orphan_resp, 1'b1);
        for (int c = 0; c < 3; c++) begin
            settle();
            tick();
        end

        // Random traffic against the model (includes dropped-valid-under-lock cases)
        for (int c = 0; c < 400; c++) begin
            req_valid          = N'($urandom);
            req_data           = {$urandom, $urandom, $urandom};
            sgpr_rd_req_ready  = ($urandom_range(0, 3) != 0);
            resp_ready         = N'($urandom);
            sgpr_rd_resp_valid = ($urandom_range(0, 2) != 0);
            sgpr_rd_resp_data  = {$urandom, $urandom};
            settle();
            tick();
        end

        // Asynchronous reset mid-burst, then an orphan after reset
        req_valid          = '1;
        sgpr_rd_req_ready  = 1'b1;
        sgpr_rd_resp_valid = 1'b0;
        settle(); tick();
        settle(); tick();
        resp_ready         = '1;
        sgpr_rd_resp_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        req_valid = '0;
        settle();
        tick();
        chk("post_reset_orphan", err_orphan_resp, 1'b1);
        sgpr_rd_resp_valid = 1'b0;
        settle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
